// File: rtl/seg7_flash_stage.sv
// rtl/seg7_flash_stage.sv - registered seven-segment output stage with timed digit blinking
// Optional build macro SEG7_FREEZE_EN: blink phases show a frame snapshot taken at the request.
module seg7_flash_stage #(
    parameter int TICKS_PER_HALF = 25000000,
    parameter int CNT_W          = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [41:0] frame_in,
    input  logic        flash_req,
    input  logic [3:0]  flash_count,
    input  logic [5:0]  digit_mask,
    output logic [41:0] frame_out,
    output logic        busy,
    output logic        done_pulse
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OFF  = 2'd1;
    localparam logic [1:0] ON   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_HALF - 1);
    localparam logic [41:0]      ALL_DARK  = 42'h3FF_FFFF_FFFF;

    logic [1:0]       state;
    logic [CNT_W-1:0] tickCnt;
    logic [3:0]       periodsLeft;
    logic [5:0]       maskLatch;
    logic             zeroDone;
    logic             tickLast;
    logic             acceptReq;
    logic [41:0]      srcFrame;
    logic [41:0]      nextFrame;

    assign tickLast  = (tickCnt == TICK_LAST);
    assign acceptReq = (state == IDLE) && flash_req && (flash_count != 4'd0);

`ifdef SEG7_FREEZE_EN
    logic [41:0] snapFrame;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snapFrame <= ALL_DARK;
        end else if (acceptReq) begin
            snapFrame <= frame_in;
        end
    end

    assign srcFrame = ((state == OFF) || (state == ON)) ? snapFrame : frame_in;
`else
    assign srcFrame = frame_in;
`endif

    always_comb begin
        nextFrame = srcFrame;
        if (state == OFF) begin
            for (int d = 0; d < 6; d++) begin
                if (maskLatch[d]) begin
                    nextFrame[d*7 +: 7] = 7'h7F;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tickCnt     <= '0;
            periodsLeft <= 4'd0;
            maskLatch   <= 6'd0;
            zeroDone    <= 1'b0;
            frame_out   <= ALL_DARK;
        end else begin
            frame_out <= nextFrame;
            // A zero-length request completes without ever leaving IDLE.
            zeroDone  <= (state == IDLE) && flash_req && (flash_count == 4'd0);
            case (state)
                IDLE: begin
                    if (acceptReq) begin
                        periodsLeft <= flash_count;
                        maskLatch   <= digit_mask;
                        tickCnt     <= '0;
                        state       <= OFF;
                    end
                end
                OFF: begin
                    if (tickLast) begin
                        tickCnt <= '0;
                        state   <= ON;
                    end else begin
                        tickCnt <= tickCnt + CNT_W'(1);
                    end
                end
                ON: begin
                    if (tickLast) begin
                        tickCnt     <= '0;
                        periodsLeft <= periodsLeft - 4'd1;
                        state       <= (periodsLeft == 4'd1) ? DONE : OFF;
                    end else begin
                        tickCnt <= tickCnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = (state == OFF) || (state == ON);
    assign done_pulse = (state == DONE) || zeroDone;

endmodule

// File: doc/seg7_flash_stage.md
Name: seg7_flash_stage

Overview:
Output stage directly downstream of the game top level's 42-bit seven-segment bus (six digits, 7 active-low segments each, digit 5 in bits [41:35] down to digit 0 in [6:0]).
- Idle: registers the frame through unchanged.
- On a flash request: blinks a selectable set of digits for a programmable number of on/off periods, then pulses done.
- Used for crash, game-over and new-best-score attention effects before the frame reaches the board pins.

Parameters:
TICKS_PER_HALF, 25000000, clock cycles per half blink period (0.5 s at 50 MHz); legal range >= 2.
CNT_W, 25, width of the half-period tick counter; must satisfy 2^CNT_W > TICKS_PER_HALF.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset.
frame_in  input  42  live display frame, active-low segments.
flash_req  input  1  single-cycle request to start a blink sequence.
flash_count  input  4  number of full off+on blink periods; sampled with flash_req.
digit_mask  input  6  bit d=1 blinks digit d; sampled with flash_req.
frame_out  output  42  registered frame to the display pins.
busy  output  1  high while a blink sequence runs.
done_pulse  output  1  one-cycle pulse when a sequence ends.

Behaviour:
Reset (rst=0, asynchronous):
- frame_out=42'h3FF_FFFF_FFFF (all segments dark).
- busy=0, done_pulse=0, state=IDLE, counters cleared.
- Reset mid-sequence aborts immediately. No done_pulse is produced.

Frame path:
- frame_out is always registered, 1-cycle latency from frame_in.
- Blanking forces the blanked digit's 7 bits to 7'h7F.

States:
- IDLE:
  - frame_out <= frame_in; busy=0.
  - flash_req=1 and flash_count!=0: latch count and mask, clear tick counter, go to OFF; busy=1 from the next cycle.
  - flash_req=1 and flash_count==0: no blinking; done_pulse=1 on the next cycle; stay IDLE.
- OFF:
  - frame_out <= frame_in with every masked digit blanked.
  - Tick counter counts 0..TICKS_PER_HALF-1; at terminal count it clears and the state goes to ON.
- ON:
  - frame_out <= frame_in (unmasked).
  - At terminal count: the remaining-period counter decrements. If it was 1, go to DONE; else go to OFF.
- DONE:
  - One cycle. done_pulse=1; busy=0 in this cycle; frame_out <= frame_in. Go to IDLE.

Timing:
- Each phase lasts exactly TICKS_PER_HALF cycles.
- Total busy time = 2*TICKS_PER_HALF*flash_count cycles.
- Digit mask all zero: sequence still runs with full timing, but no visible change.

Boundary and concurrency rules:
- flash_req while busy (OFF/ON/DONE) is ignored. There is no queueing or restart.
- frame_in changes mid-sequence are reflected live, subject to blanking in OFF.
- flash_count=15 gives 15 periods. The remaining-period counter never wraps.
- done_pulse is never asserted in the same cycle as busy=1.

Optional Feature:
SEG7_FREEZE_EN:
- Defined: frame_in is snapshotted on the accepted flash_req cycle. OFF and ON phases display the snapshot (masked digits blanked in OFF) and ignore live frame_in until DONE. DONE and IDLE resume the live pass-through.
- Undefined: no snapshot register; live frame_in is used throughout as described above.

Test Plan:
All scenarios use TICKS_PER_HALF=4.
- Reset/pass-through: hold rst=0 -> frame_out=42'h3FFFFFFFFFF, busy=0. Release, drive frame_in=42'h0123456789A -> frame_out=42'h0123456789A one cycle later.
- Basic blink: frame_in=0, flash_req with count=2, mask=6'b100001.
  - frame_out toggles between 42'h3F80000007F (4 cycles) and 0 (4 cycles), twice.
  - busy high 16 cycles; done_pulse one cycle after the final ON phase.
- Zero count: flash_req with count=0 -> busy never rises; done_pulse=1 exactly one cycle later; frame_out tracks frame_in.
- Request while busy: second flash_req mid-OFF with count=5 -> ignored; the sequence still ends after the original 2 periods (16 busy cycles).
- Reset mid-sequence: assert rst=0 during ON -> frame_out dark immediately, busy=0, no done_pulse after release.
- SEG7_FREEZE_EN build: change frame_in during ON -> frame_out keeps the snapshot until DONE, then follows the live frame.
